// File: rtl/fml_arb_pkg.sv
// Shared definitions for the two-master FML arbiter: state encoding and bus widths.
package fml_arb_pkg;

    localparam int FML_DW        = 32;
    localparam int FML_SELW      = 4;
    localparam int BURST_LEN_DEF = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GNT_V   = 3'd1,
        GNT_C   = 3'd2,
        BURST_V = 3'd3,
        BURST_C = 3'd4
    } arb_state_t;

endpackage

// File: rtl/fml_arb2_starve.sv
// Wait counter for master C; flags c_starved once C has waited MAX_WAIT cycles with stb high.
module fml_arb2_starve
    import fml_arb_pkg::*;
#(
    parameter int MAX_WAIT = 64
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic c_stb,
    input  logic c_granted,
    input  logic c_enter,
    output logic c_starved
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;

    // Saturating count; any gap in the request or a fresh C grant restarts it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_cnt <= '0;
        end else if (!c_stb || c_enter) begin
            wait_cnt <= '0;
        end else if (!c_granted && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign c_starved = (wait_cnt == WAIT_MAX);

endmodule

// File: rtl/fml_arb2.sv
// Burst arbiter sharing one FML slave between video (V, priority) and CPU/DMA (C, bounded wait).
// Optional hit counters are built when FML_ARB2_STATS_EN is defined.
module fml_arb2
    import fml_arb_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int MAX_WAIT  = 64,
    parameter int ADR_W     = 32
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [ADR_W-1:0]    v_adr,
    input  logic                v_stb,
    output logic                v_ack,
    output logic [FML_DW-1:0]   v_di,
    input  logic [ADR_W-1:0]    c_adr,
    input  logic                c_stb,
    input  logic                c_we,
    input  logic [FML_SELW-1:0] c_sel,
    input  logic [FML_DW-1:0]   c_do,
    output logic                c_ack,
    output logic [FML_DW-1:0]   c_di,
    output logic [ADR_W-1:0]    s_adr,
    output logic                s_stb,
    output logic                s_we,
    output logic [FML_SELW-1:0] s_sel,
    output logic [FML_DW-1:0]   s_do,
    input  logic                s_ack,
`ifdef FML_ARB2_STATS_EN
    input  logic                stat_clr,
    output logic [15:0]         stat_v,
    output logic [15:0]         stat_c,
`endif
    input  logic [FML_DW-1:0]   s_di
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BEAT_INIT = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(1);

    arb_state_t       state, state_nx;
    logic [CNT_W-1:0] beat_cnt, beat_nx;
    logic             c_starved;
    logic             c_granted;
    logic             c_enter;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_nx;
        end
    end

    // A dropped stb before ack is treated as an abort; the grant is released without an ack.
    always_comb begin
        state_nx = state;
        beat_nx  = beat_cnt;
        unique case (state)
            IDLE: begin
                if (c_stb && c_starved)  state_nx = GNT_C;
                else if (v_stb)          state_nx = GNT_V;
                else if (c_stb)          state_nx = GNT_C;
            end
            GNT_V: begin
                if (!v_stb) begin
                    state_nx = IDLE;
                end else if (s_ack) begin
                    if (BURST_LEN == 1) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = BURST_V;
                        beat_nx  = BEAT_INIT;
                    end
                end
            end
            GNT_C: begin
                if (!c_stb) begin
                    state_nx = IDLE;
                end else if (s_ack) begin
                    if (BURST_LEN == 1) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = BURST_C;
                        beat_nx  = BEAT_INIT;
                    end
                end
            end
            BURST_V, BURST_C: begin
                beat_nx = beat_cnt - 1'b1;
                if (beat_cnt == BEAT_LAST) state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
                beat_nx  = '0;
            end
        endcase
    end

    // Slave-side mux; write controls stay on C's values for its whole burst.
    always_comb begin
        s_stb = 1'b0;
        s_adr = '0;
        s_we  = 1'b0;
        s_sel = '0;
        s_do  = '0;
        v_ack = 1'b0;
        c_ack = 1'b0;
        unique case (state)
            GNT_V: begin
                s_stb = v_stb;
                s_adr = v_adr;
                s_sel = '1;
                v_ack = s_ack & v_stb;
            end
            BURST_V: begin
                s_sel = '1;
            end
            GNT_C: begin
                s_stb = c_stb;
                s_adr = c_adr;
                s_we  = c_we;
                s_sel = c_sel;
                s_do  = c_do;
                c_ack = s_ack & c_stb;
            end
            BURST_C: begin
                s_we  = c_we;
                s_sel = c_sel;
                s_do  = c_do;
            end
            default: begin
                s_stb = 1'b0;
            end
        endcase
    end

    assign v_di = s_di;
    assign c_di = s_di;

    assign c_granted = (state == GNT_C) || (state == BURST_C);
    assign c_enter   = (state == IDLE) && (state_nx == GNT_C);

    fml_arb2_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .c_stb     (c_stb),
        .c_granted (c_granted),
        .c_enter   (c_enter),
        .c_starved (c_starved)
    );

`ifdef FML_ARB2_STATS_EN
    // Transaction counters bump on the ack cycle; clear wins over a same-cycle ack.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stat_v <= '0;
            stat_c <= '0;
        end else if (stat_clr) begin
            stat_v <= '0;
            stat_c <= '0;
        end else begin
            if (v_ack) stat_v <= stat_v + 16'd1;
            if (c_ack) stat_c <= stat_c + 16'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_fml_arb2.sv
// Bench for fml_arb2: directed scenarios plus random traffic against a transaction-level model.
module tb_fml_arb2;

    localparam int BL = 4;
    localparam int MW = 8;
    localparam int AW = 32;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic [AW-1:0] v_adr, c_adr, s_adr;
    logic          v_stb, v_ack, c_stb, c_we, c_ack, s_stb, s_we, s_ack;
    logic [31:0]   v_di, c_di, c_do, s_do, s_di;
    logic [3:0]    c_sel, s_sel;
`ifdef FML_ARB2_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_v, stat_c;
`endif

    always #5 sys_clk = ~sys_clk;

    fml_arb2 #(.BURST_LEN(BL), .MAX_WAIT(MW), .ADR_W(AW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .v_adr     (v_adr),
        .v_stb     (v_stb),
        .v_ack     (v_ack),
        .v_di      (v_di),
        .c_adr     (c_adr),
        .c_stb     (c_stb),
        .c_we      (c_we),
        .c_sel     (c_sel),
        .c_do      (c_do),
        .c_ack     (c_ack),
        .c_di      (c_di),
        .s_adr     (s_adr),
        .s_stb     (s_stb),
        .s_we      (s_we),
        .s_sel     (s_sel),
        .s_do      (s_do),
        .s_ack     (s_ack),
`ifdef FML_ARB2_STATS_EN
        .stat_clr  (stat_clr),
        .stat_v    (stat_v),
        .stat_c    (stat_c),
`endif
        .s_di      (s_di)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: who owns the port (0 none, 1 V, 2 C), whether the ack already came,
    // how many data beats remain, and how long C has been kept waiting.
    int  own   = 0;
    bit  burst = 0;
    int  left  = 0;
    int  wcnt  = 0;
    int  sv    = 0;
    int  sc    = 0;
    logic          gp, xs, e_stb, e_we, e_vack, e_cack, cgr, take_c;
    logic [AW-1:0] e_adr;
    logic [3:0]    e_sel;
    logic [31:0]   e_do;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            own = 0; burst = 0; left = 0; wcnt = 0; sv = 0; sc = 0;
            chk("rst_s_stb", s_stb, 0);
            chk("rst_s_sel", s_sel, 0);
            chk("rst_acks", {v_ack, c_ack}, 0);
        end else begin
            gp     = (own != 0) && !burst;
            xs     = (own == 1) ? v_stb : c_stb;
            e_stb  = gp ? xs : 1'b0;
            e_adr  = !gp ? '0 : ((own == 1) ? v_adr : c_adr);
            e_we   = (own == 2) ? c_we : 1'b0;
            e_sel  = (own == 1) ? 4'hF : ((own == 2) ? c_sel : 4'h0);
            e_do   = (own == 2) ? c_do : 32'h0;
            e_vack = gp && (own == 1) && v_stb && s_ack;
            e_cack = gp && (own == 2) && c_stb && s_ack;
            chk("m_s_stb", s_stb, e_stb);
            chk("m_s_adr", s_adr, e_adr);
            chk("m_s_we", s_we, e_we);
            chk("m_s_sel", s_sel, e_sel);
            chk("m_s_do", s_do, e_do);
            chk("m_v_ack", v_ack, e_vack);
            chk("m_c_ack", c_ack, e_cack);
            chk("m_di", {v_di, c_di}, {s_di, s_di});
`ifdef FML_ARB2_STATS_EN
            chk("m_stat_v", stat_v, sv[15:0]);
            chk("m_stat_c", stat_c, sc[15:0]);
            if (stat_clr) begin
                sv = 0; sc = 0;
            end else begin
                if (e_vack) sv = (sv + 1) % 65536;
                if (e_cack) sc = (sc + 1) % 65536;
            end
`endif
            cgr    = (own == 2);
            take_c = 1'b0;
            if (own == 0) begin
                if (c_stb && wcnt == MW) begin own = 2; take_c = 1'b1; end
                else if (v_stb)          own = 1;
                else if (c_stb)          begin own = 2; take_c = 1'b1; end
            end else if (!burst) begin
                if (!xs) own = 0;
                else if (s_ack) begin
                    if (BL == 1) own = 0;
                    else begin burst = 1; left = BL - 1; end
                end
            end else begin
                left--;
                if (left == 0) begin own = 0; burst = 0; end
            end
            if (!c_stb || take_c)      wcnt = 0;
            else if (!cgr && wcnt < MW) wcnt++;
        end
    end

    bit rnd = 0;
    bit v_hold, c_hold, v_got, c_got;
    int lat_fix, sl_lat, sl_cnt;
    int va, ca, nva, va2, beats;

    task automatic set_lat(input int l);
        lat_fix = l; sl_lat = l; sl_cnt = 0;
    endtask

    // One clock: masters update at +1, slave answers at +2, acks are sampled at +3.
    task automatic step();
        @(posedge sys_clk); #1;
        if (rnd) begin
            if (v_got)                           v_stb = 1'($urandom_range(0, 1));
            else if (!v_stb)                     v_stb = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 31) == 0) v_stb = 1'b0;
            if (c_got)                           c_stb = 1'($urandom_range(0, 1));
            else if (!c_stb)                     c_stb = ($urandom_range(0, 2) == 0);
            else if ($urandom_range(0, 31) == 0) c_stb = 1'b0;
            v_adr = $urandom; c_adr = $urandom; c_do = $urandom;
            c_we  = 1'($urandom_range(0, 1));
            c_sel = 4'($urandom_range(0, 15));
`ifdef FML_ARB2_STATS_EN
            stat_clr = ($urandom_range(0, 31) == 0);
`endif
        end else begin
            if (v_got) v_stb = v_hold;
            if (c_got) c_stb = c_hold;
        end
        s_di = $urandom;
        #1;
        s_ack = 1'b0;
        if (s_stb) begin
            if (sl_cnt >= sl_lat) begin
                s_ack  = 1'b1;
                sl_cnt = 0;
                sl_lat = rnd ? int'($urandom_range(0, 3)) : lat_fix;
            end else begin
                sl_cnt++;
            end
        end else begin
            sl_cnt = 0;
        end
        #1;
        v_got = v_ack; c_got = c_ack;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        v_stb = 1'b1; c_stb = 1'b1; v_adr = 32'h55; c_adr = 32'hAA;
        c_we = 1'b1; c_sel = 4'hF; c_do = 32'h1234; s_ack = 1'b1; s_di = 0;
        v_hold = 0; c_hold = 0; v_got = 0; c_got = 0;
`ifdef FML_ARB2_STATS_EN
        stat_clr = 1'b0;
`endif
        set_lat(3);
        #3;
        chk("reset_outputs", {s_stb, s_we, s_sel, s_adr, v_ack, c_ack}, 0);
        chk("reset_s_do", s_do, 0);
        v_stb = 0; c_stb = 0; c_we = 0; c_sel = 0; c_do = 0; s_ack = 0;
        repeat (2) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        step(); step();

        // Single V read, slave acks 3 cycles after s_stb rises.
        set_lat(3); v_adr = 32'h1000; v_stb = 1'b1;
        #1 chk("v_req_latency", s_stb, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) chk("v_adr", s_adr, 32'h1000);
            if (k <= 4) chk("v_stb_gnt", {s_stb, v_ack, c_ack}, {1'b1, k == 4, 1'b0});
            else if (k <= 7) chk("v_burst_hold", {s_stb, s_sel, v_ack}, {1'b0, 4'hF, 1'b0});
            else chk("v_idle_after", s_sel, 0);
        end

        // Single C write.
        set_lat(1); c_we = 1; c_sel = 4'h3; c_do = 32'hDEADBEEF; c_adr = 32'h2000; c_stb = 1;
        beats = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (c_ack) beats = 0;
            if (beats >= 0 && beats < 4) begin
                chk("c_wr_beat", {s_we, s_sel, s_do}, {1'b1, 4'h3, 32'hDEADBEEF});
                beats++;
            end else if (beats == 4) begin
                chk("c_wr_s_do_after", s_do, 0);
                beats++;
            end
        end
        chk("c_wr_beats_seen", beats, 5);
        c_we = 0; c_sel = 0; c_do = 0;

        // Simultaneous request: V first, C right after V's burst plus one IDLE.
        set_lat(3); va = -1; ca = -1; v_stb = 1; c_stb = 1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (v_ack) va = k;
            if (c_ack) ca = k;
        end
        chk("simul_v_ack_cycle", va, 4);
        chk("simul_c_ack_cycle", ca, 12);

        // Starvation: V hammers, C held; C overrides once its wait reaches MAX_WAIT.
        set_lat(0); v_hold = 1; c_hold = 1; v_stb = 1;
        for (int i = 0; i < 10 && !v_got; i++) step();
        chk("starve_first_v_ack", v_got, 1);
        step();
        c_stb = 1; nva = 0; ca = -1; va2 = -1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (v_ack && ca < 0) nva++;
            if (c_ack && ca < 0) ca = k;
            if (v_ack && ca > 0 && va2 < 0) va2 = k;
        end
        chk("starve_v_acks_before_c", nva, 1);
        chk("starve_c_ack_cycle", ca, 9);
        chk("starve_v_after_clear", va2, 14);
        v_hold = 0; c_hold = 0; c_stb = 0;
        repeat (8) step();

        // Abort: V drops stb in GNT_V before any ack.
        set_lat(10); v_stb = 1;
        step();
        chk("abort_gnt", s_stb, 1);
        v_stb = 0;
        #1 chk("abort_stb_drop", s_stb, 0);
        step();
        chk("abort_no_ack", {s_stb, v_ack}, 0);
        v_stb = 1;
        #1 chk("abort_back_idle", s_stb, 0);
        step();
        chk("abort_regrant", s_stb, 1);
        v_stb = 0;
        repeat (3) step();

        // Asynchronous reset in the middle of a C burst.
        set_lat(0); c_stb = 1; c_we = 1; c_sel = 4'hA; c_do = 32'h12345678;
        step();
        chk("rst_c_ack", c_ack, 1);
        step();
        chk("rst_in_burst", {s_sel, s_do}, {4'hA, 32'h12345678});
        sys_rst_n = 1'b0;
        #1 chk("rst_async", {s_stb, s_we, s_sel, s_do}, 0);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1; c_stb = 1; set_lat(0);
        #1 chk("rst_idle_after", s_stb, 0);
        step();
        chk("rst_regrant_c", c_ack, 1);
        c_we = 0; c_sel = 0; c_do = 0;
        repeat (6) step();

`ifdef FML_ARB2_STATS_EN
        stat_clr = 1; step(); stat_clr = 0;
        set_lat(0);
        repeat (5) begin v_stb = 1; repeat (6) step(); end
        repeat (3) begin c_stb = 1; repeat (6) step(); end
        chk("stat_v_count", stat_v, 5);
        chk("stat_c_count", stat_c, 3);
        v_stb = 1;
        step();
        chk("stat_clr_on_ack", v_ack, 1);
        stat_clr = 1;
        step();
        stat_clr = 0;
        chk("stat_cleared", {stat_v, stat_c}, 0);
        repeat (6) step();
`endif

        // Random traffic, checked cycle by cycle against the model.
        rnd = 1;
        repeat (4000) step();
        rnd = 0; v_stb = 0; c_stb = 0;
`ifdef FML_ARB2_STATS_EN
        stat_clr = 0;
`endif
        repeat (8) step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/fml_arb2.md
Name: fml_arb2

Overview:
- Two-master arbiter that shares the framebuffer FML memory port between the video pixel fetcher (master V, read-only, latency-critical) and a general CPU/DMA master (master C, read/write).
- Sits between the video framebuffer's FML master port, the system bridge and the memory controller's FML slave.
- Grants whole bursts, favours V, and guarantees C a bounded wait.

Parameters:
- BURST_LEN, 4: data beats per FML transaction, counted from the ack cycle inclusive; must be at least 1.
- MAX_WAIT, 64: cycles C may wait with stb high before it overrides V priority.
- ADR_W, 32: address width.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- v_adr  in  ADR_W  master V address
- v_stb  in  1  master V request
- v_ack  out  1  master V ack
- v_di  out  32  master V read data
- c_adr  in  ADR_W  master C address
- c_stb  in  1  master C request
- c_we  in  1  master C write enable
- c_sel  in  4  master C byte enables
- c_do  in  32  master C write data
- c_ack  out  1  master C ack
- c_di  out  32  master C read data
- s_adr  out  ADR_W  slave address
- s_stb  out  1  slave request
- s_we  out  1  slave write enable
- s_sel  out  4  slave byte enables
- s_do  out  32  slave write data
- s_ack  in  1  slave ack
- s_di  in  32  slave read data

Behaviour:
- Clock/reset: one clock, sys_clk. Reset is asynchronous, active-low (sys_rst_n).
- Reset values: state IDLE, grant none, burst counter 0, wait counter 0. s_stb, s_we, v_ack and c_ack are 0; s_sel is 4'h0; s_adr and s_do are 0.
- States: IDLE, GNT_V, GNT_C, BURST_V, BURST_C.
- IDLE arbitration, registered:
  - If c_stb is high and the wait counter equals MAX_WAIT, go to GNT_C.
  - Else if v_stb is high, go to GNT_V.
  - Else if c_stb is high, go to GNT_C.
  - Else stay in IDLE.
- Request latency: a request arriving in IDLE sees s_stb at the next cycle at the earliest.
- GNT_x:
  - s_stb = x_stb; s_adr = x_adr.
  - s_we = c_we for C and 0 for V.
  - s_sel = c_sel for C and 4'hF for V.
  - s_ack is routed combinationally to x_ack only; the other master's ack is 0.
  - On s_ack, go to BURST_x with counter = BURST_LEN-1, or to IDLE if BURST_LEN == 1.
  - If x_stb drops before ack (protocol violation), return to IDLE with no ack issued.
- Data during a burst (ack cycle plus the BURST_x cycles):
  - s_di is driven to both v_di and c_di unconditionally; only the granted master consumes it.
  - s_do = c_do while C owns the burst, else 0.
- BURST_x: hold the grant and decrement the counter each cycle. At counter == 1 the next state is IDLE. The grant never changes mid-burst.
- Wait counter:
  - Increments each cycle in which c_stb is high and C is not granted; saturates at MAX_WAIT.
  - Clears on entry to GNT_C and whenever c_stb is low.
  - Width is $clog2(MAX_WAIT+1).
- One IDLE cycle always separates consecutive grants, so there is no back-to-back bursting.
- s_stb is never asserted outside GNT_x.
- Simultaneous requests in IDLE resolve by the priority above. A new request during a burst waits for IDLE.
- Reset mid-burst returns to the reset state immediately; the slave is expected to be reset by the same signal.

Optional Feature:
- Macro: FML_ARB2_STATS_EN.
- When defined:
  - Adds input stat_clr (1 bit) and outputs stat_v (16 bits) and stat_c (16 bits).
  - Each counter increments by 1 on the ack cycle of its master's transaction and wraps 16'hFFFF to 0.
  - stat_clr zeroes both counters synchronously and takes precedence over an increment in the same cycle.
  - Both counters reset to 0.
- When undefined: these ports and the counter logic do not exist; arbitration behaviour is identical.

Decomposition:
- Shared package fml_arb_pkg:
  - state encoding typedef (IDLE/GNT_V/GNT_C/BURST_V/BURST_C)
  - FML_DW = 32, FML_SELW = 4
  - default BURST_LEN
- Natural sub-module: fml_arb2_starve, containing the wait counter and saturation compare. It outputs c_starved. All else is flat.

Test Plan:
- Single V read: v_stb=1 in IDLE, s_ack 3 cycles after s_stb. Expect v_ack pulsed 1 cycle, c_ack=0, grant held 3 beats after ack, IDLE then 1 cycle.
- Single C write: c_we=1, c_sel=4'h3, c_do=32'hDEADBEEF. Expect s_we=1, s_sel=4'h3, s_do=32'hDEADBEEF during the 4 beats, and s_do=0 afterwards.
- Simultaneous request: v_stb and c_stb rise together in IDLE. Expect V granted first, C granted in the IDLE following V's last beat.
- Starvation: V re-requests continuously while c_stb is held. With MAX_WAIT=8, expect C granted at the first IDLE after its wait counter reaches 8, before V's next grant, and the counter cleared.
- Abort and reset: drop v_stb in GNT_V before ack, expect IDLE next cycle with no ack. Assert sys_rst_n=0 during BURST_C, expect s_stb=0 and state IDLE asynchronously.
- Stats (macro on): 5 V and 3 C transactions, expect stat_v=5, stat_c=3. Pulse stat_clr on a V ack cycle, expect both counters 0.
